// File: rtl/ksa_gen.sv
// RC4 key-scheduling engine driving a single-port S memory (sync read, one access per cycle).
// Optional identity fill, then 256 swap iterations of 6 cycles each.
module ksa_gen #(
    parameter int KEY_BYTES = 3,
    parameter bit DO_INIT   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [5:0]             key_len,
    output logic [7:0]             addr,
    input  logic [7:0]             rddata,
    output logic [7:0]             wrdata,
    output logic                   wren,
    output logic [2:0]             state_dbg
);

    // Handshake: en is accepted only at an edge where rdy=1; rdy drops the next cycle until the run ends.
    typedef enum logic [2:0] {IDLE, FILL, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J} state_t;

    state_t                 state, state_d;
    logic [7:0]             i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [5:0]             kidx_q, kidx_d, len_q, len_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic [7:0]             addr_d, wrdata_d;
    logic                   wren_d;
    logic [7:0]             key_byte, j_sum;

    assign rdy       = (state == IDLE);
    assign state_dbg = state;

    always_comb begin
        key_byte = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (kidx_q == 6'(b)) key_byte = key_q[8*(KEY_BYTES-1-b) +: 8];
        end
    end

    // rddata holds S[i] in WT_I, so the new j is formed there and presented as the RD_J address.
    assign j_sum = j_q + rddata + key_byte;

    // Output registers are loaded with the action of the state being entered.
    always_comb begin
        state_d  = state;
        i_d      = i_q;
        j_d      = j_q;
        si_d     = si_q;
        sj_d     = sj_q;
        kidx_d   = kidx_q;
        len_d    = len_q;
        key_d    = key_q;
        addr_d   = addr;
        wrdata_d = wrdata;
        wren_d   = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    key_d    = key;
                    len_d    = (key_len == 6'd0 || key_len > 6'(KEY_BYTES)) ? 6'(KEY_BYTES) : key_len;
                    i_d      = 8'd0;
                    j_d      = 8'd0;
                    kidx_d   = 6'd0;
                    addr_d   = 8'd0;
                    wrdata_d = 8'd0;
                    if (DO_INIT) begin
                        wren_d  = 1'b1;
                        state_d = FILL;
                    end else begin
                        state_d = RD_I;
                    end
                end
            end
            FILL: begin
                if (i_q == 8'hFF) begin
                    i_d     = 8'd0;
                    addr_d  = 8'd0;
                    state_d = RD_I;
                end else begin
                    i_d      = i_q + 8'd1;
                    addr_d   = i_q + 8'd1;
                    wrdata_d = i_q + 8'd1;
                    wren_d   = 1'b1;
                end
            end
            RD_I: state_d = WT_I;
            WT_I: begin
                si_d    = rddata;
                j_d     = j_sum;
                addr_d  = j_sum;
                state_d = RD_J;
            end
            RD_J: state_d = WT_J;
            WT_J: begin
                sj_d     = rddata;
                addr_d   = i_q;
                wrdata_d = rddata;
                wren_d   = 1'b1;
                state_d  = WR_I;
            end
            WR_I: begin
                addr_d   = j_q;
                wrdata_d = si_q;
                wren_d   = 1'b1;
                state_d  = WR_J;
            end
            WR_J: begin
                if (i_q == 8'hFF) begin
                    state_d = IDLE;
                end else begin
                    i_d     = i_q + 8'd1;
                    addr_d  = i_q + 8'd1;
                    kidx_d  = (kidx_q == 6'(len_q - 6'd1)) ? 6'd0 : kidx_q + 6'd1;
                    state_d = RD_I;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            i_q    <= '0;
            j_q    <= '0;
            si_q   <= '0;
            sj_q   <= '0;
            kidx_q <= '0;
            len_q  <= '0;
            key_q  <= '0;
            addr   <= '0;
            wrdata <= '0;
            wren   <= 1'b0;
        end else begin
            state  <= state_d;
            i_q    <= i_d;
            j_q    <= j_d;
            si_q   <= si_d;
            sj_q   <= sj_d;
            kidx_q <= kidx_d;
            len_q  <= len_d;
            key_q  <= key_d;
            addr   <= addr_d;
            wrdata <= wrdata_d;
            wren   <= wren_d;
        end
    end

endmodule

// File: doc/ksa_gen.md
KSA_GEN -- requirements
Module: ksa_gen

Interface
REQ-001 Parameter KEY_BYTES, default 3, maximum key length in bytes (1..32).
REQ-002 Parameter DO_INIT, default 1, where 1 means the block fills S[i]=i before scheduling and 0 means the block skips the fill.
REQ-003 Port clk, input, 1, the single clock, with all state updated on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port en, input, 1, start request, sampled only while rdy=1.
REQ-006 Port rdy, output, 1, high while idle and able to accept en.
REQ-007 Port key, input, 8*KEY_BYTES, key bytes with byte 0 in the most significant byte.
REQ-008 Port key_len, input, 6, number of active key bytes.
REQ-009 Port addr, output, 8, S-memory address.
REQ-010 Port rddata, input, 8, S-memory read data, valid in the cycle after a read address is presented.
REQ-011 Port wrdata, output, 8, S-memory write data.
REQ-012 Port wren, output, 1, S-memory write enable, one write per cycle.

Function
REQ-013 States SHALL be IDLE, FILL, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J.
REQ-014 In IDLE, rdy=1 and wren=0; in every other state, rdy=0.
REQ-015 At the edge where en=1 and the block is in IDLE, it SHALL latch key and effective length L, clear i and j, and go to FILL if DO_INIT=1, else to RD_I.
REQ-016 L SHALL equal key_len; key_len=0 or key_len>KEY_BYTES SHALL give L=KEY_BYTES.
REQ-017 en while rdy=0 SHALL be ignored, and key and key_len changes while busy SHALL have no effect.
REQ-018 FILL SHALL write addr=i, wrdata=i, wren=1 for i=0..255, one per cycle, then reset i=0 and go to RD_I.
REQ-019 RD_I SHALL drive addr=i, wren=0.
REQ-020 WT_I SHALL capture si=rddata.
REQ-021 RD_J SHALL compute j=(j+si+key byte (i mod L)) mod 256 and drive addr=new j, wren=0.
REQ-022 WT_J SHALL capture sj=rddata.
REQ-023 WR_I SHALL write addr=i, wrdata=sj.
REQ-024 WR_J SHALL write addr=j, wrdata=si.
REQ-025 After WR_J, if i=255 the block SHALL go to IDLE; otherwise i SHALL increment and the block SHALL go to RD_I.
REQ-026 Each iteration SHALL take exactly 6 cycles.
REQ-027 All index and sum arithmetic SHALL be 8-bit modulo 256.
REQ-028 The i mod L counter SHALL be a separate counter wrapping at L-1, with no divider.
REQ-029 When i=j, both writes SHALL target the same address with the same value, leaving S unchanged.
REQ-030 Latency from the accepting edge E0 to rdy=1 SHALL be 1792 cycles with DO_INIT=1 and 1536 cycles with DO_INIT=0.
REQ-031 en=1 in the cycle rdy returns high SHALL be accepted at that edge, giving back-to-back runs.
REQ-032 addr, wrdata and wren SHALL be registered outputs.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, rdy=1, wren=0, addr=0, wrdata=0, and i, j, si, sj and the key index to 0.
REQ-034 Reset during any state SHALL abort the run with no further writes.
REQ-035 After rst_n rises, the next en SHALL start a fresh run.

Verification
REQ-036 key=0x000000, L=3, DO_INIT=1 -> writes (a,a) for a=0..255, then (0,0),(0,0),(1,1),(1,1),(2,3),(3,2); rdy rises 1792 cycles after E0.
REQ-037 DO_INIT=0, memory preloaded S[i]=i, key=0x000000 -> first write pairs match the iteration pairs of REQ-036; rdy rises at E0+1536.
REQ-038 KEY_BYTES=3, key=0x00033C, key_len=0 and then key_len=3 -> identical write sequences; final S matches a software RC4 KSA model for key 00 03 3C.
REQ-039 key_len=1, key=0x0A0000 -> final S matches the model for the single-byte key 0A.
REQ-040 rst_n pulled low at cycle 900 of a run -> rdy=1 and wren=0 with no clock edge required; a new en run then completes correctly.
REQ-041 en held high continuously -> en ignored while busy, and a second run starts at the edge rdy reasserts.
